// File: rtl/axi_4_lite_mst_pkg.sv
// Shared widths, AXI response codes and master FSM encodings for axi_4_lite_mst.
// Width/response macros keep their configuration-header names and may be predefined by the build.
`ifndef C_AXI_ADDR_WIDTH
`define C_AXI_ADDR_WIDTH 32
`endif
`ifndef C_AXI_DATA_WIDTH
`define C_AXI_DATA_WIDTH 32
`endif
`ifndef C_AXI_STROBE_WIDTH
`define C_AXI_STROBE_WIDTH (`C_AXI_DATA_WIDTH/8)
`endif
`ifndef AXI_RESP_OKAY
`define AXI_RESP_OKAY 2'b00
`endif
`ifndef AXI_RESP_SLVERR
`define AXI_RESP_SLVERR 2'b10
`endif
`ifndef AXI_RESP_DECERR
`define AXI_RESP_DECERR 2'b11
`endif

package axi_4_lite_mst_pkg;

  localparam int AXI_ADDR_WIDTH = `C_AXI_ADDR_WIDTH;
  localparam int AXI_DATA_WIDTH = `C_AXI_DATA_WIDTH;
  localparam int AXI_STRB_WIDTH = `C_AXI_STROBE_WIDTH;

  localparam logic [1:0] RESP_OKAY   = `AXI_RESP_OKAY;
  localparam logic [1:0] RESP_SLVERR = `AXI_RESP_SLVERR;
  localparam logic [1:0] RESP_DECERR = `AXI_RESP_DECERR;

  typedef enum logic [2:0] {
    MST_IDLE    = 3'd0,
    MST_WR      = 3'd1,
    MST_WR_RESP = 3'd2,
    MST_RD_ADDR = 3'd3,
    MST_RD_DATA = 3'd4,
    MST_RSP     = 3'd5
  } mst_state_e;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_4_lite_mst_ch.sv
// VALID-hold register for one AXI request channel (AW, W or AR): raised by start,
// held until the handshake, with a sticky flag so split AW/W handshakes can be joined.
module axi_4_lite_mst_ch (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic ready,
  output logic valid,
  output logic complete
);

  logic done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid  <= 1'b0;
      done_q <= 1'b0;
    end else if (start) begin
      valid  <= 1'b1;
      done_q <= 1'b0;
    end else if (valid && ready) begin
      valid  <= 1'b0;
      done_q <= 1'b1;
    end
  end

  // Complete in the handshake cycle itself so the FSM advances without an extra bubble.
  assign complete = done_q | (valid & ready);

endmodule

// File: rtl/axi_4_lite_mst.sv
// AXI4-Lite master: one command in, one single-beat AXI transaction, one response out.
// Optional debug counters are enabled with the AXI_4_LITE_MST_DEBUG_EN macro.
//
// state       | meaning
// IDLE        | CMD_READY high, waiting for a command
// WR          | AW and W outstanding, tracked independently
// WR_RESP     | BREADY high, waiting for BVALID
// RD_ADDR     | ARVALID held until ARREADY
// RD_DATA     | RREADY high, waiting for RVALID
// RSP         | RSP_VALID high until RSP_READY
module axi_4_lite_mst
  import axi_4_lite_mst_pkg::*;
#(
  parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH = AXI_DATA_WIDTH,
  parameter int STRB_WIDTH = AXI_STRB_WIDTH
`ifdef AXI_4_LITE_MST_DEBUG_EN
  , parameter int DEB_CNT_WIDTH = 16
`endif
) (
  input  logic                  M_AXI_ACLK,
  input  logic                  M_AXI_ARESETN,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic                  CMD_WRITE,
  input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
  input  logic [DATA_WIDTH-1:0] CMD_WDATA,
  input  logic [STRB_WIDTH-1:0] CMD_WSTRB,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [DATA_WIDTH-1:0] RSP_RDATA,
  output logic [1:0]            RSP_RESP,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [2:0]            M_AXI_AWPROT,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  output logic [DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic [STRB_WIDTH-1:0] M_AXI_WSTRB,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,
  input  logic [1:0]            M_AXI_BRESP,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0]            M_AXI_ARPROT,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY,
  input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP
`ifdef AXI_4_LITE_MST_DEBUG_EN
  , output logic [DEB_CNT_WIDTH-1:0] DEB_WR_COUNT
  , output logic [DEB_CNT_WIDTH-1:0] DEB_RD_COUNT
  , output logic [DEB_CNT_WIDTH-1:0] DEB_ERR_COUNT
`endif
);

  mst_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            resp_q;

  logic accept, wr_start, rd_start, b_hs, r_hs;
  logic aw_complete, w_complete, ar_complete;

  assign accept   = CMD_VALID & CMD_READY;
  assign wr_start = accept & CMD_WRITE;
  assign rd_start = accept & ~CMD_WRITE;
  assign b_hs     = M_AXI_BVALID & M_AXI_BREADY;
  assign r_hs     = M_AXI_RVALID & M_AXI_RREADY;

  axi_4_lite_mst_ch u_aw (
    .clk(M_AXI_ACLK), .rst_n(M_AXI_ARESETN), .start(wr_start),
    .ready(M_AXI_AWREADY), .valid(M_AXI_AWVALID), .complete(aw_complete)
  );

  axi_4_lite_mst_ch u_w (
    .clk(M_AXI_ACLK), .rst_n(M_AXI_ARESETN), .start(wr_start),
    .ready(M_AXI_WREADY), .valid(M_AXI_WVALID), .complete(w_complete)
  );

  axi_4_lite_mst_ch u_ar (
    .clk(M_AXI_ACLK), .rst_n(M_AXI_ARESETN), .start(rd_start),
    .ready(M_AXI_ARREADY), .valid(M_AXI_ARVALID), .complete(ar_complete)
  );

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) state_q <= MST_IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    CMD_READY    = 1'b0;
    M_AXI_BREADY = 1'b0;
    M_AXI_RREADY = 1'b0;
    RSP_VALID    = 1'b0;
    case (state_q)
      MST_IDLE: begin
        // Held low while reset is asserted so only the released master advertises ready.
        CMD_READY = M_AXI_ARESETN;
        if (CMD_VALID && M_AXI_ARESETN) state_d = CMD_WRITE ? MST_WR : MST_RD_ADDR;
      end
      MST_WR:      if (aw_complete && w_complete) state_d = MST_WR_RESP;
      MST_WR_RESP: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) state_d = MST_RSP;
      end
      MST_RD_ADDR: if (ar_complete) state_d = MST_RD_DATA;
      MST_RD_DATA: begin
        M_AXI_RREADY = 1'b1;
        if (M_AXI_RVALID) state_d = MST_RSP;
      end
      MST_RSP: begin
        RSP_VALID = 1'b1;
        if (RSP_READY) state_d = MST_IDLE;
      end
      default: state_d = MST_IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      resp_q  <= '0;
    end else begin
      if (accept) begin
        addr_q  <= CMD_ADDR;
        wdata_q <= CMD_WDATA;
        wstrb_q <= CMD_WSTRB;
      end
      if (b_hs) begin
        rdata_q <= '0;
        resp_q  <= M_AXI_BRESP;
      end else if (r_hs) begin
        rdata_q <= M_AXI_RDATA;
        resp_q  <= M_AXI_RRESP;
      end
    end
  end

  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_WDATA  = wdata_q;
  assign M_AXI_WSTRB  = wstrb_q;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign RSP_RDATA    = rdata_q;
  assign RSP_RESP     = resp_q;

`ifdef AXI_4_LITE_MST_DEBUG_EN
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      DEB_WR_COUNT  <= '0;
      DEB_RD_COUNT  <= '0;
      DEB_ERR_COUNT <= '0;
    end else begin
      if (b_hs) DEB_WR_COUNT <= DEB_WR_COUNT + DEB_CNT_WIDTH'(1);
      if (r_hs) DEB_RD_COUNT <= DEB_RD_COUNT + DEB_CNT_WIDTH'(1);
      if ((b_hs && resp_is_err(M_AXI_BRESP)) || (r_hs && resp_is_err(M_AXI_RRESP)))
        DEB_ERR_COUNT <= DEB_ERR_COUNT + DEB_CNT_WIDTH'(1);
    end
  end
`else
  // Debug counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_axi_4_lite_mst.sv
// Bench for axi_4_lite_mst with a behavioural AXI4-Lite slave and a response scoreboard.
// Debug-counter checks are included when AXI_4_LITE_MST_DEBUG_EN is defined.
module tb_axi_4_lite_mst;
  import axi_4_lite_mst_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [2:0]  awprot, arprot;
  logic [1:0]  bresp, rresp;
`ifdef AXI_4_LITE_MST_DEBUG_EN
  logic [15:0] deb_wr, deb_rd, deb_err;
`endif

  always #5 clk = ~clk;

  axi_4_lite_mst dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rstn),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_WRITE(cmd_write),
    .CMD_ADDR(cmd_addr), .CMD_WDATA(cmd_wdata), .CMD_WSTRB(cmd_wstrb),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_RDATA(rsp_rdata), .RSP_RESP(rsp_resp),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready), .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
    .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_BRESP(bresp),
    .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready), .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp)
`ifdef AXI_4_LITE_MST_DEBUG_EN
    , .DEB_WR_COUNT(deb_wr), .DEB_RD_COUNT(deb_rd), .DEB_ERR_COUNT(deb_err)
`endif
  );

  // ---------------- behavioural slave ----------------
  int          aw_stall = 0, w_stall = 0, ar_stall = 0;
  logic        b_block = 1'b0, rd_err = 1'b0;
  int          aw_cnt, w_cnt, ar_cnt;
  logic [31:0] mem [0:31];
  logic [31:0] ref_mem [0:31];
  logic        have_aw, have_w, bvalid_q, rvalid_q;
  logic [31:0] aw_l, wd_l, rdata_q;
  logic [3:0]  ws_l;
  logic [1:0]  rresp_q;
  logic        aw_hs, w_hs, ar_hs, wr_fire;
  logic [31:0] eff_addr, eff_data;
  logic [3:0]  eff_strb;

  assign awready  = awvalid && (aw_cnt >= aw_stall);
  assign wready   = wvalid && (w_cnt >= w_stall);
  assign arready  = arvalid && (ar_cnt >= ar_stall);
  assign aw_hs    = awvalid & awready;
  assign w_hs     = wvalid & wready;
  assign ar_hs    = arvalid & arready;
  assign eff_addr = aw_hs ? awaddr : aw_l;
  assign eff_data = w_hs ? wdata : wd_l;
  assign eff_strb = w_hs ? wstrb : ws_l;
  assign wr_fire  = (have_aw | aw_hs) & (have_w | w_hs);
  assign bvalid   = bvalid_q & ~b_block;
  assign bresp    = RESP_OKAY;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign rresp    = rresp_q;

  always @(posedge clk) begin
    if (!rstn) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      have_aw <= 1'b0; have_w <= 1'b0; bvalid_q <= 1'b0; rvalid_q <= 1'b0;
      aw_l <= '0; wd_l <= '0; ws_l <= '0; rdata_q <= '0; rresp_q <= '0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      if (aw_hs) aw_l <= awaddr;
      if (w_hs) begin wd_l <= wdata; ws_l <= wstrb; end
      if (wr_fire) begin
        for (int b = 0; b < 4; b++)
          if (eff_strb[b]) mem[eff_addr[6:2]][8*b +: 8] <= eff_data[8*b +: 8];
        have_aw <= 1'b0; have_w <= 1'b0; bvalid_q <= 1'b1;
      end else begin
        if (aw_hs) have_aw <= 1'b1;
        if (w_hs)  have_w  <= 1'b1;
        if (bvalid && bready) bvalid_q <= 1'b0;
      end
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= mem[araddr[6:2]];
        rresp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (rvalid && rready) rvalid_q <= 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed { logic [31:0] rdata; logic [1:0] resp; } exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;

  task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input bit err, input int exp_lat,
                         input int exp_aw, input int exp_w, input int hold);
    exp_t e, got;
    int t, cyc, aw_cyc, w_cyc;
    bit aw_prev, w_prev;
    logic [31:0] a;
    a = addr;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    rd_err = err;
    t = 0;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    if (!cmd_ready) begin
      n_cmp++; n_bad++; $display("FAIL cmd_ready_timeout actual=0 required=1");
    end
    if (wr) begin
      e.rdata = '0; e.resp = RESP_OKAY;
      for (int b = 0; b < 4; b++) if (strb[b]) ref_mem[a[6:2]][8*b +: 8] = data[8*b +: 8];
    end else begin
      e.rdata = ref_mem[a[6:2]]; e.resp = err ? RESP_SLVERR : RESP_OKAY;
    end
    sb.push_back(e);
    @(posedge clk);
    cyc = 0; aw_cyc = 0; w_cyc = 0; aw_prev = 0; w_prev = 0;
    while (cyc < 100) begin
      @(negedge clk); cyc++;
      cmd_valid = 1'b0;
      if (aw_prev) begin
        n_cmp++;
        if (awvalid !== 1'b0) begin n_bad++; $display("FAIL awvalid_drop cyc=%0d actual=%b required=0", cyc, awvalid); end
      end
      if (w_prev) begin
        n_cmp++;
        if (wvalid !== 1'b0) begin n_bad++; $display("FAIL wvalid_drop cyc=%0d actual=%b required=0", cyc, wvalid); end
      end
      aw_prev = aw_hs; w_prev = w_hs;
      if (aw_hs) begin
        aw_cyc = cyc; n_cmp++;
        if (awaddr !== addr) begin n_bad++; $display("FAIL awaddr actual=%h required=%h", awaddr, addr); end
      end
      if (w_hs) begin
        w_cyc = cyc; n_cmp++;
        if (wdata !== data || wstrb !== strb) begin
          n_bad++; $display("FAIL wpayload actual=%h/%h required=%h/%h", wdata, wstrb, data, strb);
        end
      end
      if (ar_hs) begin
        n_cmp++;
        if (araddr !== addr) begin n_bad++; $display("FAIL araddr actual=%h required=%h", araddr, addr); end
      end
      if (rsp_valid) break;
    end
    if (!rsp_valid) begin
      n_cmp++; n_bad++; $display("FAIL rsp_timeout actual=0 required=1");
      return;
    end
    if (exp_lat > 0) begin
      n_cmp++;
      if (cyc != exp_lat) begin n_bad++; $display("FAIL latency actual=%0d required=%0d", cyc, exp_lat); end
    end
    if (exp_aw > 0) begin
      n_cmp++;
      if (aw_cyc != exp_aw || w_cyc != exp_w) begin
        n_bad++; $display("FAIL hs_cycles actual=%0d/%0d required=%0d/%0d", aw_cyc, w_cyc, exp_aw, exp_w);
      end
    end
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++; $display("FAIL sb_empty actual=0 required=1");
    end else begin
      e = sb.pop_front();
      got.rdata = rsp_rdata; got.resp = rsp_resp;
      if (got !== e) begin
        n_bad++; $display("FAIL rsp addr=%h actual=%h/%b required=%h/%b", addr, rsp_rdata, rsp_resp, e.rdata, e.resp);
      end
    end
    for (int k = 0; k < hold; k++) begin
      if (k == 1) begin
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addr; cmd_wdata = 32'h0; cmd_wstrb = 4'hF;
      end
      if (k == 3) cmd_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_resp !== e.resp || cmd_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL rsp_hold k=%0d actual=%b/%h/%b/%b required=1/%h/%b/0", k, rsp_valid, rsp_rdata, rsp_resp, cmd_ready, e.rdata, e.resp);
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    n_cmp++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL rsp_release actual=%b/%b required=0/1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid} !== 6'b0) begin
      n_bad++; $display("FAIL reset_valids actual=%b required=000000", {awvalid, wvalid, arvalid, bready, rready, rsp_valid});
    end
    n_cmp++;
    if (awaddr !== 0 || araddr !== 0 || wdata !== 0 || wstrb !== 0 || rsp_rdata !== 0 || rsp_resp !== 0) begin
      n_bad++; $display("FAIL reset_payload actual=%h/%h/%h/%h required=0", awaddr, wdata, rsp_rdata, rsp_resp);
    end
    rstn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_ready actual=%b required=1", cmd_ready); end
  endtask

  task automatic test_write_read();
    run_cmd(1, 32'h00, 32'hDEADBEEF, 4'hF, 0, 3, 1, 1, 0);
    run_cmd(0, 32'h00, 32'h0, 4'h0, 0, 3, 0, 0, 0);
  endtask

  task automatic test_strobes();
    run_cmd(1, 32'h14, 32'hFFFFFFFF, 4'hF, 0, 3, 0, 0, 0);
    run_cmd(1, 32'h14, 32'h00563400, 4'h6, 0, 3, 0, 0, 0);
    run_cmd(1, 32'h14, 32'h11223344, 4'h0, 0, 3, 0, 0, 0);
    run_cmd(0, 32'h14, 32'h0, 4'h0, 0, 3, 0, 0, 0);
    run_cmd(1, 32'h2B, 32'h0BADF00D, 4'hF, 0, 3, 0, 0, 0);
    run_cmd(0, 32'h29, 32'h0, 4'h0, 0, 3, 0, 0, 0);
  endtask

  task automatic test_stall();
    aw_stall = 1; w_stall = 3;
    run_cmd(1, 32'h7C, 32'hA5A5A5A5, 4'hF, 0, 6, 2, 4, 0);
    aw_stall = 3; w_stall = 0;
    run_cmd(1, 32'h70, 32'h5A5A0001, 4'hF, 0, 6, 4, 1, 0);
    aw_stall = 0; w_stall = 0; ar_stall = 2;
    run_cmd(0, 32'h7C, 32'h0, 4'h0, 0, 5, 0, 0, 0);
    ar_stall = 0;
  endtask

  task automatic test_rsp_hold();
    run_cmd(0, 32'h7C, 32'h0, 4'h0, 0, 3, 0, 0, 5);
    run_cmd(0, 32'h7C, 32'h0, 4'h0, 0, 3, 0, 0, 0);
  endtask

  task automatic test_error();
    run_cmd(0, 32'h00, 32'h0, 4'h0, 1, 3, 0, 0, 0);
    rd_err = 1'b0;
  endtask

  task automatic test_reset_mid();
    int t;
    b_block = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40; cmd_wdata = 32'h12345678; cmd_wstrb = 4'hF;
    ref_mem[16] = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    t = 0;
    while (!bready && t < 50) begin @(negedge clk); t++; end
    n_cmp++;
    if (bready !== 1'b1) begin n_bad++; $display("FAIL wr_resp_reach actual=%b required=1", bready); end
    rstn = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid} !== 6'b0) begin
      n_bad++; $display("FAIL midreset_valids actual=%b required=000000", {awvalid, wvalid, arvalid, bready, rready, rsp_valid});
    end
    rstn = 1'b1; b_block = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL midreset_cmd_ready actual=%b required=1", cmd_ready); end
    run_cmd(0, 32'h40, 32'h0, 4'h0, 0, 3, 0, 0, 0);
    run_cmd(0, 32'h14, 32'h0, 4'h0, 0, 3, 0, 0, 0);
  endtask

`ifdef AXI_4_LITE_MST_DEBUG_EN
  task automatic test_debug();
    apply_reset();
    run_cmd(1, 32'h04, 32'h00000001, 4'hF, 0, 3, 0, 0, 0);
    run_cmd(1, 32'h08, 32'h00000002, 4'hF, 0, 3, 0, 0, 0);
    run_cmd(1, 32'h0C, 32'h00000003, 4'hF, 0, 3, 0, 0, 0);
    run_cmd(0, 32'h04, 32'h0, 4'h0, 0, 3, 0, 0, 0);
    run_cmd(0, 32'h08, 32'h0, 4'h0, 1, 3, 0, 0, 0);
    rd_err = 1'b0;
    n_cmp++;
    if (deb_wr !== 16'd3 || deb_rd !== 16'd2 || deb_err !== 16'd1) begin
      n_bad++; $display("FAIL debug_counts actual=%0d/%0d/%0d required=3/2/1", deb_wr, deb_rd, deb_err);
    end
  endtask
`endif

  initial begin
    rstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    test_reset();
    test_write_read();
    test_strobes();
    test_stall();
    test_rsp_hold();
    test_error();
    test_reset_mid();
`ifdef AXI_4_LITE_MST_DEBUG_EN
    test_debug();
`endif
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL sb_leftover actual=%0d required=0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
